// File: rtl/fragment_header_inserter.sv
// fragment_header_inserter: prepends a magic/seq/index/length header beat to each
// tlast-delimited 64-bit fragment and flags fragments whose length mismatches the header.
module fragment_header_inserter #(
  parameter logic [15:0] MAGIC    = 16'hA5C3,
  parameter logic [15:0] SEQ_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        transfer_init,
  input  logic [31:0] mss,
  input  logic [31:0] transfer_size,
  output logic        len_error,
  output logic [15:0] frag_count
);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DRAIN} state_t;
  state_t      r_state;
  logic        r_init_d;
  logic        r_first;
  logic [31:0] r_mss;
  logic [31:0] r_remaining;
  logic [15:0] r_seq;
  logic [15:0] r_frag_idx;
  logic [15:0] r_cnt;
  logic [63:0] r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_tuser;
  logic        r_len_error;
  logic        w_edge;
  logic        w_load_ok;
  logic        w_accept;
  logic        w_last_frag;
  logic [31:0] w_min;
  logic [14:0] w_exp;
  logic [31:0] w_rem_next;
  logic [15:0] w_cnt_inc;
  assign w_edge        = transfer_init && !r_init_d;
  assign w_load_ok     = !r_tvalid || m_axis_tready;
  assign s_axis_tready = (r_state == PAYLOAD) && w_load_ok;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_min         = (r_remaining < r_mss) ? r_remaining : r_mss;
  assign w_exp         = (|w_min[31:15]) ? 15'h7FFF : w_min[14:0];
  assign w_last_frag   = r_remaining <= r_mss;
  // Subtract the (possibly saturated) announced length, clamping at zero.
  assign w_rem_next    = (r_remaining > {17'd0, w_exp}) ? r_remaining - {17'd0, w_exp} : 32'd0;
  assign w_cnt_inc     = r_cnt + 16'd1;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign len_error     = r_len_error;
  assign frag_count    = r_frag_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_init_d    <= 1'b0;
      r_first     <= 1'b1;
      r_mss       <= 32'd0;
      r_remaining <= 32'd0;
      r_seq       <= SEQ_INIT;
      r_frag_idx  <= 16'd0;
      r_cnt       <= 16'd0;
      r_tdata     <= 64'd0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_len_error <= 1'b0;
    end else begin
      r_init_d    <= transfer_init;
      r_len_error <= 1'b0;
      if (m_axis_tready) r_tvalid <= 1'b0;
      case (r_state)
        IDLE: if (w_edge) begin
          r_mss       <= mss;
          r_remaining <= transfer_size;
          r_frag_idx  <= 16'd0;
          r_cnt       <= 16'd0;
          r_seq       <= r_first ? r_seq : r_seq + 16'd1;
          r_first     <= 1'b0;
          r_state     <= HEADER;
        end
        HEADER: if (!transfer_init) r_state <= DRAIN;
        else if (w_load_ok) begin
          r_tvalid <= 1'b1;
          r_tdata  <= {MAGIC, r_seq, r_frag_idx, w_last_frag, w_exp};
          r_tlast  <= 1'b0;
          r_tuser  <= 1'b0;
          r_state  <= PAYLOAD;
        end
        PAYLOAD: if (w_accept) begin
          r_tvalid    <= 1'b1;
          r_tdata     <= s_axis_tdata;
          r_tlast     <= s_axis_tlast;
          r_tuser     <= s_axis_tuser;
          r_cnt       <= s_axis_tlast ? 16'd0 : w_cnt_inc;
          r_len_error <= s_axis_tlast ? (w_cnt_inc != {1'b0, w_exp}) : (w_cnt_inc == {1'b0, w_exp});
          if (s_axis_tlast) begin
            r_remaining <= w_rem_next;
            r_frag_idx  <= r_frag_idx + 16'd1;
            r_state     <= (w_rem_next == 32'd0 || !transfer_init) ? DRAIN : HEADER;
          end
        end
        DRAIN: if (!r_tvalid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fragment_header_inserter.sv
// tb_fragment_header_inserter: randomized fragment streams checked against a queue-based header/payload model.
module tb_fragment_header_inserter;
  localparam logic [15:0] MAGIC    = 16'hA5C3;
  localparam logic [15:0] SEQ_INIT = 16'h0000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        transfer_init = 1'b0;
  logic [31:0] mss = '0;
  logic [31:0] transfer_size = '0;
  logic        len_error;
  logic [15:0] frag_count;
  int          n_vec = 0;
  int          n_err = 0;
  logic [65:0] src_q[$];
  logic [65:0] exp_q[$];
  int          lens_q[$];
  int          exp_errs;
  int          exp_frags;
  int          exp_total;
  bit          first = 1'b1;
  logic [15:0] seq_last = '0;

  fragment_header_inserter dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .transfer_init(transfer_init), .mss(mss), .transfer_size(transfer_size),
    .len_error(len_error), .frag_count(frag_count)
  );

  always #5 clk = ~clk;

  // Builds source beats and the expected output stream for the fragment lengths in lens_q.
  task automatic begin_transfer(input longint m, input longint sz);
    longint      rem;
    longint      e;
    int          idx;
    logic [15:0] sq;
    logic [63:0] d;
    logic        u;
    logic        l;
    rem = sz;
    idx = 0;
    sq = first ? SEQ_INIT : seq_last + 16'd1;
    first = 1'b0;
    seq_last = sq;
    exp_errs = 0;
    foreach (lens_q[f]) begin
      e = (rem < m) ? rem : m;
      if (e > 32767) e = 32767;
      exp_q.push_back({2'b00, MAGIC, sq, 16'(idx), (rem <= m), 15'(e)});
      for (int b = 0; b < lens_q[f]; b++) begin
        d = {$urandom, $urandom};
        u = 1'($urandom_range(0, 1));
        l = (b == lens_q[f] - 1);
        src_q.push_back({u, l, d});
        exp_q.push_back({u, l, d});
      end
      exp_errs += (lens_q[f] < e) ? 1 : (lens_q[f] > e) ? 2 : 0;
      rem = (rem > e) ? rem - e : 0;
      idx++;
    end
    exp_frags = idx;
    exp_total = exp_q.size();
    mss = 32'(m);
    transfer_size = 32'(sz);
    transfer_init = 1'b1;
  endtask

  task automatic run(input int rp, input int ip, input bit chk_lat);
    int          cyc = 0;
    int          errs = 0;
    int          first_v = -1;
    int          tail = 0;
    int          outn = 0;
    bit          stalled = 1'b0;
    bit          taken = 1'b0;
    logic [65:0] prev = '0;
    logic [65:0] got;
    while ((exp_q.size() > 0 || tail < 4) && cyc < 4000) begin
      if (taken) begin
        void'(src_q.pop_front());
        s_axis_tvalid = 1'b0;
      end
      if (!s_axis_tvalid && src_q.size() > 0) s_axis_tvalid = ($urandom_range(0, 99) < ip);
      if (s_axis_tvalid) {s_axis_tuser, s_axis_tlast, s_axis_tdata} = src_q[0];
      m_axis_tready = ($urandom_range(0, 99) < rp);
      #1;
      got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (len_error) errs++;
      if (stalled) begin
        n_vec++;
        if (!m_axis_tvalid || got !== prev) begin
          n_err++;
          $display("FAIL stall_hold: got %h valid %b, required %h valid 1", got, m_axis_tvalid, prev);
        end
      end
      if (m_axis_tvalid && first_v < 0) first_v = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        outn++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat: got %h, required no beat", got);
        end else begin
          if (got !== exp_q[0]) begin
            n_err++;
            $display("FAIL beat%0d: got %h, required %h", outn, got, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      prev = got;
      taken = s_axis_tvalid && s_axis_tready;
      if (exp_q.size() == 0) tail++;
      @(negedge clk);
      cyc++;
    end
    if (taken) void'(src_q.pop_front());
    s_axis_tvalid = 1'b0;
    n_vec++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout: %0d output and %0d input beats left, required 0", exp_q.size(), src_q.size());
      exp_q.delete();
      src_q.delete();
    end
    n_vec++;
    if (outn != exp_total) begin
      n_err++;
      $display("FAIL beat_count: got %0d, required %0d", outn, exp_total);
    end
    n_vec++;
    if (errs != exp_errs) begin
      n_err++;
      $display("FAIL len_error_pulses: got %0d, required %0d", errs, exp_errs);
    end
    n_vec++;
    if (frag_count !== 16'(exp_frags)) begin
      n_err++;
      $display("FAIL frag_count: got %0d, required %0d", frag_count, exp_frags);
    end
    if (chk_lat) begin
      n_vec++;
      if (first_v != 2) begin
        n_err++;
        $display("FAIL header_latency: got %0d, required 2", first_v);
      end
    end
  endtask

  task automatic end_transfer();
    transfer_init = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_m_ctrl: got %b, required 000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser});
    end
    n_vec++;
    if (m_axis_tdata !== 64'd0) begin
      n_err++;
      $display("FAIL reset_m_data: got %h, required 0", m_axis_tdata);
    end
    n_vec++;
    if ({s_axis_tready, len_error, frag_count} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_status: got %h, required 0", {s_axis_tready, len_error, frag_count});
    end
    rst = 1'b0;
    first = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    lens_q = '{4, 4, 2};
    begin_transfer(4, 10);
    run(100, 100, 1'b1);
    end_transfer();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 2; t++) begin
      lens_q = '{3, 3};
      begin_transfer(3, 6);
      run(100, 100, 1'b1);
      end_transfer();
    end
  endtask

  task automatic test_random_stall();
    lens_q.delete();
    repeat (8) lens_q.push_back(8);
    begin_transfer(8, 64);
    run(50, 75, 1'b0);
    end_transfer();
    lens_q = '{5, 5, 5, 5, 3};
    begin_transfer(5, 23);
    run(50, 100, 1'b0);
    end_transfer();
  endtask

  task automatic test_len_error();
    lens_q = '{3, 4};
    begin_transfer(4, 8);
    run(100, 100, 1'b0);
    end_transfer();
  endtask

  task automatic test_saturation();
    int w = 0;
    lens_q = '{1};
    begin_transfer(40000, 100000);
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    while (!m_axis_tvalid && w < 10) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (m_axis_tdata !== exp_q[0][63:0] || !m_axis_tvalid) begin
      n_err++;
      $display("FAIL sat_header: got %h valid %b, required %h", m_axis_tdata, m_axis_tvalid, exp_q[0][63:0]);
    end
    exp_q.delete();
    src_q.delete();
    rst = 1'b1;
    transfer_init = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    first = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    lens_q = '{4, 4};
    begin_transfer(4, 8);
    m_axis_tready = 1'b1;
    repeat (5) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = {$urandom, $urandom};
      s_axis_tlast = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    transfer_init = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 67'd0) begin
      n_err++;
      $display("FAIL midreset_out: got %h, required 0", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata});
    end
    n_vec++;
    if ({s_axis_tready, len_error, frag_count} !== 18'd0) begin
      n_err++;
      $display("FAIL midreset_status: got %h, required 0", {s_axis_tready, len_error, frag_count});
    end
    rst = 1'b0;
    first = 1'b1;
    exp_q.delete();
    src_q.delete();
    @(negedge clk);
    lens_q = '{4};
    begin_transfer(4, 4);
    run(100, 100, 1'b1);
    end_transfer();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random_stall();
    test_len_error();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
